// File: rtl/core_pkg.sv
// Shared core definitions: register file geometry and the writeback request record.
package core_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  // x0 is hardwired to zero, so writes to it are dropped and it is never busy
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] sel;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: two requesters competing for the register file write port,
// plus the registered write port itself.
interface regfile_wb_arbiter_if
  import core_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) ();

  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_sel;
  logic [DATA_W-1:0] req0_data;

  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_sel;
  logic [DATA_W-1:0] req1_data;

  logic              rf_w_en;
  logic [ADDR_W-1:0] rf_w_sel;
  logic [DATA_W-1:0] rf_w_data;

  // Requester side (execute / load units) and observer of the write port
  modport master (
    output req0_valid, req0_sel, req0_data,
    input  req0_ready,
    output req1_valid, req1_sel, req1_data,
    input  req1_ready,
    input  rf_w_en, rf_w_sel, rf_w_data
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_sel, req0_data,
    output req0_ready,
    input  req1_valid, req1_sel, req1_data,
    output req1_ready,
    output rf_w_en, rf_w_sel, rf_w_data
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. On a tie the requester that did not win last
// time is granted; grants are suppressed entirely while en is low.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // Index of the requester granted most recently; resets to 1 so req0 wins the first tie
  logic last_grant;

  // One-hot grant selection from the request pair and the round-robin pointer
  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Advance the pointer only when a grant is actually issued
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the execute and load writeback
// paths, and keeps a per-register pending-write mask for RAW hazard checks.
module regfile_wb_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W,
  parameter int NREG   = NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rf_rdy,
  regfile_wb_arbiter_if.slave wb,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_sel,
  input  logic [ADDR_W-1:0] chk_sel_1,
  input  logic [ADDR_W-1:0] chk_sel_2,
  output logic              chk_busy_1,
  output logic              chk_busy_2,
  output logic              sb_err
);

  wb_req_t r0;
  wb_req_t r1;
  wb_req_t win;
  logic [1:0] grant;
  logic       xfer;
  logic       wr_live;
  logic       rsv_live;

  logic              w_en_q;
  logic [ADDR_W-1:0] w_sel_q;
  logic [DATA_W-1:0] w_data_q;

  logic [NREG-1:0] mask;
  logic [NREG-1:0] mask_nxt;
  logic            err_hit;

  assign r0 = '{valid: wb.req0_valid, sel: wb.req0_sel, data: wb.req0_data};
  assign r1 = '{valid: wb.req1_valid, sel: wb.req1_sel, data: wb.req1_data};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rf_rdy),
    .req   ({r1.valid, r0.valid}),
    .grant (grant)
  );

  assign wb.req0_ready = grant[0];
  assign wb.req1_ready = grant[1];

  assign xfer     = |grant;
  assign win      = grant[1] ? r1 : r0;
  assign wr_live  = xfer && win.valid && (win.sel != REG_ZERO);
  assign rsv_live = rsv_en && rf_rdy && (rsv_sel != REG_ZERO);

  // Register the winning request onto the write port; x0 targets are consumed silently
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_en_q   <= 1'b0;
      w_sel_q  <= '0;
      w_data_q <= '0;
    end else begin
      w_en_q <= wr_live;
      if (xfer) begin
        w_sel_q  <= win.sel;
        w_data_q <= win.data;
      end
    end
  end

  assign wb.rf_w_en   = w_en_q;
  assign wb.rf_w_sel  = w_sel_q;
  assign wb.rf_w_data = w_data_q;

  // Next pending mask: clear on write, then set on reservation so a newer writer wins
  always_comb begin
    mask_nxt = mask;
    err_hit  = 1'b0;
    if (wr_live) begin
      mask_nxt[win.sel] = 1'b0;
    end
    if (rsv_live) begin
      mask_nxt[rsv_sel] = 1'b1;
      err_hit = mask[rsv_sel] && !(wr_live && (win.sel == rsv_sel));
    end
    mask_nxt[0] = 1'b0;
  end

  // Pending mask is held empty until the register file has finished clearing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask   <= '0;
      sb_err <= 1'b0;
    end else if (!rf_rdy) begin
      mask <= '0;
    end else begin
      mask <= mask_nxt;
      if (err_hit) begin
        sb_err <= 1'b1;
      end
    end
  end

  assign chk_busy_1 = mask[chk_sel_1];
  assign chk_busy_2 = mask[chk_sel_2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a reference model predicts each
// registered write, queues it, and compares it when the write port updates.
module tb_regfile_wb_arbiter;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rf_rdy;
  logic        rsv_en;
  logic [4:0]  rsv_sel;
  logic [4:0]  chk_sel_1;
  logic [4:0]  chk_sel_2;
  logic        chk_busy_1;
  logic        chk_busy_2;
  logic        sb_err;

  regfile_wb_arbiter_if wb ();

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rf_rdy     (rf_rdy),
    .wb         (wb),
    .rsv_en     (rsv_en),
    .rsv_sel    (rsv_sel),
    .chk_sel_1  (chk_sel_1),
    .chk_sel_2  (chk_sel_2),
    .chk_busy_1 (chk_busy_1),
    .chk_busy_2 (chk_busy_2),
    .sb_err     (sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [4:0]  sel;
    logic [31:0] data;
    bit          check_all;
  } exp_t;

  exp_t exp_q[$];
  int   vec_count   = 0;
  int   miscompares = 0;

  bit          m_last;
  logic [31:0] m_mask;
  bit          m_err;

  // One clock: predict the write from current inputs, update the model, then compare.
  task automatic tick();
    exp_t        e;
    bit          g0, g1, xfer;
    logic [4:0]  s;
    logic [31:0] d;
    logic [31:0] nm;
    g0   = rf_rdy && wb.req0_valid && (!wb.req1_valid || m_last);
    g1   = rf_rdy && wb.req1_valid && (!wb.req0_valid || !m_last);
    xfer = g0 || g1;
    s    = g1 ? wb.req1_sel  : wb.req0_sel;
    d    = g1 ? wb.req1_data : wb.req0_data;
    if (!rst_n) begin
      e.en = 1'b0; e.sel = 5'd0; e.data = 32'd0; e.check_all = 1'b1;
    end else begin
      e.en = xfer && (s != 5'd0); e.sel = s; e.data = d; e.check_all = 1'b0;
    end
    exp_q.push_back(e);
    if (!rst_n) begin
      m_last = 1'b1; m_mask = '0; m_err = 1'b0;
    end else begin
      if (xfer) m_last = g1;
      if (!rf_rdy) begin
        m_mask = '0;
      end else begin
        nm = m_mask;
        if (xfer && s != 5'd0) nm[s] = 1'b0;
        if (rsv_en && rsv_sel != 5'd0) begin
          if (m_mask[rsv_sel] && !(xfer && s == rsv_sel)) m_err = 1'b1;
          nm[rsv_sel] = 1'b1;
        end
        m_mask = nm;
      end
    end
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    vec_count++;
    if (wb.rf_w_en !== e.en) begin
      miscompares++;
      $display("[TB] FAIL rf_w_en: got %b expected %b", wb.rf_w_en, e.en);
    end
    if (e.en || e.check_all) begin
      vec_count++;
      if (wb.rf_w_sel !== e.sel) begin
        miscompares++;
        $display("[TB] FAIL rf_w_sel: got %0d expected %0d", wb.rf_w_sel, e.sel);
      end
      vec_count++;
      if (wb.rf_w_data !== e.data) begin
        miscompares++;
        $display("[TB] FAIL rf_w_data: got %h expected %h", wb.rf_w_data, e.data);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst_n = 1'b0; rf_rdy = 1'b0; rsv_en = 1'b0;
    tick();
    tick();
    chk_sel_1 = 5'd1; chk_sel_2 = 5'd31;
    #1;
    vec_count++;
    if (chk_busy_1 !== 1'b0 || chk_busy_2 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_busy: got %b%b expected 00", chk_busy_1, chk_busy_2);
    end
    vec_count++;
    if (sb_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_sb_err: got %b expected 0", sb_err);
    end
  endtask

  task automatic test_startup();
    $display("[TB] test_startup");
    rst_n = 1'b1; rf_rdy = 1'b0;
    wb.req0_valid = 1'b1; wb.req0_sel = 5'd5; wb.req0_data = 32'hDEADBEEF;
    for (int i = 0; i < 40; i++) begin
      #1;
      vec_count++;
      if (wb.req0_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL startup_ready cycle %0d: got %b expected 0", i, wb.req0_ready);
      end
      tick();
    end
    rf_rdy = 1'b1;
    #1;
    vec_count++;
    if (wb.req0_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL startup_ready_on: got %b expected 1", wb.req0_ready);
    end
    tick();
    wb.req0_valid = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g1;
    $display("[TB] test_round_robin");
    do_reset();
    exp_g1 = 4'b1010;
    wb.req0_valid = 1'b1; wb.req0_sel = 5'd3; wb.req0_data = 32'h11;
    wb.req1_valid = 1'b1; wb.req1_sel = 5'd4; wb.req1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      vec_count++;
      if (wb.req0_ready !== !exp_g1[i] || wb.req1_ready !== exp_g1[i]) begin
        miscompares++;
        $display("[TB] FAIL rr_grant %0d: got r0=%b r1=%b expected r1=%b", i,
                 wb.req0_ready, wb.req1_ready, exp_g1[i]);
      end
      tick();
    end
    wb.req0_valid = 1'b0; wb.req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_x0_drop();
    $display("[TB] test_x0_drop");
    rsv_en = 1'b1; rsv_sel = 5'd12;
    tick();
    rsv_en = 1'b0;
    wb.req1_valid = 1'b1; wb.req1_sel = 5'd0; wb.req1_data = 32'hFFFFFFFF;
    #1;
    vec_count++;
    if (wb.req1_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL x0_ready: got %b expected 1", wb.req1_ready);
    end
    tick();
    wb.req1_valid = 1'b0;
    chk_sel_1 = 5'd12; chk_sel_2 = 5'd0;
    #1;
    vec_count++;
    if (chk_busy_1 !== 1'b1 || chk_busy_2 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL x0_mask: got %b%b expected 10", chk_busy_1, chk_busy_2);
    end
    wb.req0_valid = 1'b1; wb.req0_sel = 5'd12; wb.req0_data = 32'hC0C0;
    tick();
    wb.req0_valid = 1'b0;
  endtask

  task automatic test_scoreboard();
    $display("[TB] test_scoreboard");
    rsv_en = 1'b1; rsv_sel = 5'd7;
    tick();
    rsv_en = 1'b0; chk_sel_1 = 5'd7;
    #1;
    vec_count++;
    if (chk_busy_1 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sb_set: got %b expected 1", chk_busy_1);
    end
    wb.req0_valid = 1'b1; wb.req0_sel = 5'd7; wb.req0_data = 32'h77;
    tick();
    wb.req0_valid = 1'b0;
    #1;
    vec_count++;
    if (chk_busy_1 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sb_clear: got %b expected 0", chk_busy_1);
    end
    rsv_en = 1'b1; rsv_sel = 5'd7;
    tick();
    wb.req0_valid = 1'b1; wb.req0_sel = 5'd7; wb.req0_data = 32'h78;
    tick();
    rsv_en = 1'b0; wb.req0_valid = 1'b0;
    #1;
    vec_count++;
    if (chk_busy_1 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sb_set_wins: got %b expected 1", chk_busy_1);
    end
    vec_count++;
    if (sb_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sb_err_same_cycle: got %b expected 0", sb_err);
    end
    wb.req0_valid = 1'b1; wb.req0_data = 32'h79;
    tick();
    wb.req0_valid = 1'b0;
  endtask

  task automatic test_double_rsv();
    $display("[TB] test_double_rsv");
    rsv_en = 1'b1; rsv_sel = 5'd9;
    tick();
    tick();
    rsv_en = 1'b0; chk_sel_1 = 5'd9;
    #1;
    vec_count++;
    if (sb_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL dbl_err: got %b expected 1", sb_err);
    end
    wb.req0_valid = 1'b1; wb.req0_sel = 5'd9; wb.req0_data = 32'h99;
    tick();
    wb.req0_valid = 1'b0;
    #1;
    vec_count++;
    if (chk_busy_1 !== 1'b0 || sb_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL dbl_sticky: got busy=%b err=%b expected busy=0 err=1", chk_busy_1, sb_err);
    end
    do_reset();
    #1;
    vec_count++;
    if (sb_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL dbl_reset: got %b expected 0", sb_err);
    end
  endtask

  task automatic test_reset_mid();
    $display("[TB] test_reset_mid");
    rsv_en = 1'b1; rsv_sel = 5'd14;
    tick();
    rsv_en = 1'b0;
    wb.req0_valid = 1'b1; wb.req0_sel = 5'd6; wb.req0_data = 32'h66;
    tick();
    wb.req1_valid = 1'b1; wb.req1_sel = 5'd8; wb.req1_data = 32'h88;
    rst_n = 1'b0;
    tick();
    chk_sel_1 = 5'd14; chk_sel_2 = 5'd6;
    #1;
    vec_count++;
    if (chk_busy_1 !== 1'b0 || chk_busy_2 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_busy: got %b%b expected 00", chk_busy_1, chk_busy_2);
    end
    rst_n = 1'b1; rf_rdy = 1'b0;
    tick();
    tick();
    rf_rdy = 1'b1;
    #1;
    vec_count++;
    if (wb.req0_ready !== 1'b1 || wb.req1_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_first_tie: got r0=%b r1=%b expected r0=1 r1=0",
               wb.req0_ready, wb.req1_ready);
    end
    tick();
    wb.req0_valid = 1'b0; wb.req1_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; rf_rdy = 1'b0; rsv_en = 1'b0; rsv_sel = 5'd0;
    chk_sel_1 = 5'd0; chk_sel_2 = 5'd0;
    wb.req0_valid = 1'b0; wb.req0_sel = 5'd0; wb.req0_data = 32'd0;
    wb.req1_valid = 1'b0; wb.req1_sel = 5'd0; wb.req1_data = 32'd0;
    test_reset();
    test_startup();
    test_round_robin();
    test_x0_drop();
    test_scoreboard();
    test_double_rsv();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the integer register file between two writeback requesters: req0 = ALU/execute result, req1 = load unit.
- Contains a pending-write scoreboard, one bit per architectural register, that the issue stage uses to detect RAW hazards.
- Sits between the execute/memory stages and the register file.
- Honours the register file's ready flag: nothing is accepted while the register file is still clearing itself after reset.

Parameters:
- ADDR_W, 5, register index width
- DATA_W, 32, register data width
- NREG, 32, number of architectural registers (2**ADDR_W)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- rf_rdy  in  1  register file ready (finished its post-reset clear)
- req0_valid  in  1  execute writeback request
- req0_ready  out  1  execute request accepted this cycle
- req0_sel  in  ADDR_W  execute destination register
- req0_data  in  DATA_W  execute result
- req1_valid  in  1  load writeback request
- req1_ready  out  1  load request accepted this cycle
- req1_sel  in  ADDR_W  load destination register
- req1_data  in  DATA_W  load data
- rf_w_en  out  1  register file write enable (registered)
- rf_w_sel  out  ADDR_W  register file write index (registered)
- rf_w_data  out  DATA_W  register file write data (registered)
- rsv_en  in  1  issue stage reserves a destination register
- rsv_sel  in  ADDR_W  register being reserved
- chk_sel_1  in  ADDR_W  first source register to check
- chk_sel_2  in  ADDR_W  second source register to check
- chk_busy_1  out  1  chk_sel_1 has a pending write (combinational from the mask)
- chk_busy_2  out  1  chk_sel_2 has a pending write (combinational from the mask)
- sb_err  out  1  sticky: a reservation hit a register that was already busy

Behaviour:
- **Reset (rst_n low at clk edge):**
  - rf_w_en=0, rf_w_sel=0, rf_w_data=0.
  - Pending mask = 0; sb_err=0.
  - last_grant=1, so req0 wins the first tie.
  - Reset mid-transfer discards the transfer; no rf write is issued.
- **Gate on rf_rdy:**
  - While rf_rdy=0: req0_ready=req1_ready=0, rf_w_en=0, rsv_en is ignored, and the pending mask is held at 0.
- **Grant (combinational):**
  - Only one valid: that requester is granted.
  - Both valid: the one not granted last time is granted (round-robin).
  - reqN_ready = rf_rdy & grantN. At most one ready is high per cycle.
  - Transfer occurs when reqN_valid & reqN_ready; last_grant then updates to N.
  - If no transfer occurs, last_grant holds.
  - Requesters must hold valid, sel and data stable until ready; valid must not depend on ready.
- **Write issue:**
  - One cycle after a transfer: rf_w_en=1, rf_w_sel=sel, rf_w_data=data. Latency is exactly 1 cycle.
  - A transfer with sel=0 is consumed (ready high) but gives rf_w_en=0 and does not touch the mask.
  - rf_w_en drops to 0 in any cycle without a transfer.
  - Throughput: 1 write per cycle.
- **Scoreboard mask update at clk edge:**
  - clear: bit[sel] cleared on a transfer with sel≠0 (same edge that registers the write).
  - set: bit[rsv_sel] set when rsv_en & rf_rdy & rsv_sel≠0.
  - Set and clear on the same index in the same cycle: set wins (a newer writer is outstanding).
  - Reserving an index whose bit is already 1 and not being cleared that cycle: bit stays 1, sb_err←1 (sticky until reset).
  - Bit 0 is constant 0.
- **Hazard check:**
  - chk_busy_k = mask[chk_sel_k].
  - Sampled value does not include same-cycle set/clear; forwarding is the datapath's responsibility.
- **Arithmetic:** none beyond index decode; all indices are ADDR_W bits, with no wrap cases.

Decomposition:
- Shared package core_pkg holds:
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32
  - REG_ZERO=5'd0
  - a writeback request struct (valid, sel, data)
- One sub-module, rr_arb2: a 2-way round-robin arbiter with last_grant state, enable input and one-hot grant output.
- Scoreboard and write register stay in the top module.

Test Plan:
- **Startup gating:** rst_n low 2 cycles, rf_rdy low 40 cycles with req0_valid=1, sel=5, data=0xDEADBEEF → ready stays 0 and rf_w_en=0 until rf_rdy=1; the next cycle gives ready=1, then rf_w_en=1, rf_w_sel=5, rf_w_data=0xDEADBEEF.
- **Round-robin:** both requesters valid every cycle (req0 sel=3 data=0x11, req1 sel=4 data=0x22), 4 transfers → grants are 0,1,0,1 and rf_w_sel is 3,4,3,4 on consecutive cycles after a 1-cycle lag.
- **x0 drop:** req1 transfer with sel=0, data=0xFFFFFFFF → req1_ready=1 and rf_w_en stays 0 the following cycle; the mask is unchanged.
- **Scoreboard lifecycle:**
  - rsv_en sel=7 → next cycle chk_sel_1=7 gives busy=1.
  - req0 writes sel=7 → busy=0 one cycle later.
  - rsv and transfer on sel=7 in the same cycle → busy stays 1.
- **Double reservation:** reserve sel=9 twice with no write in between → sb_err=1 and it remains 1 after the write clears bit 9; a reset sequence clears it.
- **Reset mid-operation:** transfer accepted, then rst_n low at the next edge → rf_w_en=0, all chk_busy=0, and req0 wins the first tie after rf_rdy returns.
